ff_rd_scheduler: RTL

- Sequences host reads of the three radar data FIFOs (A: 16-bit, B: 16-bit, C: 32-bit) behind the PCI register window.
- Captures per-FIFO read requests from the bus decode and arbitrates them round-robin.
- Issues a single-cycle read enable to the selected FIFO, waits the FIFO read latency, then latches the word.
- Presents the latched word with a ready strobe (drives the PCI core RD_STB_IN) until the host acknowledges, with timeout and empty-FIFO protection.

---
 rtl/ff_rd_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ff_rd_scheduler.sv
// Round-robin read sequencer for radar FIFOs A/B/C behind the PCI window.
// Issues one rden per grant, latches the word, holds it until ack or timeout.
module ff_rd_scheduler #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned TMO        = 255,
    parameter logic [31:0] EMPTY_WORD = 32'h0000_DEAD
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [2:0]  req,
    input  logic        ack,
    input  logic [2:0]  ffa_rdstate,
    input  logic [2:0]  ffb_rdstate,
    input  logic [2:0]  ffc_rdstate,
    input  logic [15:0] ffa_rddata,
    input  logic [15:0] ffb_rddata,
    input  logic [31:0] ffc_rddata,
    output logic        ffa_rden,
    output logic        ffb_rden,
    output logic        ffc_rden,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_src,
    output logic        ff_rdstb,
    output logic        busy,
    input  logic        err_clr,
    output logic        err_empty,
    output logic        err_tmo,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b,
    output logic [15:0] cnt_c
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    logic [1:0]  state;
    logic [2:0]  pend;
    logic [1:0]  ptr;
    logic [1:0]  gnt;
    logic [1:0]  gnt_nxt;
    logic [2:0]  take;
    logic        emp;
    logic [1:0]  lat_cnt;
    logic [15:0] tmo_cnt;
    logic        sel_empty;
    logic [31:0] sel_data;
    logic        issue;
    logic        latch;
    logic        tmo_hit;

    // First pending source at or after the pointer, wrapping A->B->C
    always_comb begin
        gnt_nxt = 2'd0;
        case (ptr)
            2'd1:
                gnt_nxt = pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd0;
            2'd2:
                gnt_nxt = pend[2] ? 2'd2 : pend[0] ? 2'd0 : 2'd1;
            default:
                gnt_nxt = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
        endcase
    end

    always_comb begin
        take = 3'b000;
        if (state == S_IDLE && |pend)
            take = 3'b001 << gnt_nxt;
    end

    always_comb begin
        sel_empty = ffc_rdstate[0];
        sel_data  = ffc_rddata;
        case (gnt)
            2'd0: begin
                sel_empty = ffa_rdstate[0];
                sel_data  = {16'h0000, ffa_rddata};
            end
            2'd1: begin
                sel_empty = ffb_rdstate[0];
                sel_data  = {16'h0000, ffb_rddata};
            end
            default: ;
        endcase
    end

    assign issue   = (state == S_ISSUE) && !sel_empty;
    assign latch   = (state == S_WAIT) && (lat_cnt == LAT_LAST);
    assign tmo_hit = (state == S_HOLD) && !ack
                   && (tmo_cnt == TMO_LAST);

    assign ffa_rden = issue && (gnt == 2'd0);
    assign ffb_rden = issue && (gnt == 2'd1);
    assign ffc_rden = issue && (gnt == 2'd2);
    assign ff_rdstb = (state == S_HOLD);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state   <= S_IDLE;
            pend    <= 3'b000;
            ptr     <= 2'd0;
            gnt     <= 2'd0;
            emp     <= 1'b0;
            lat_cnt <= 2'd0;
            tmo_cnt <= 16'd0;
        end else begin
            // A req landing on its own grant cycle survives the clear
            pend <= (pend & ~take) | req;
            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        gnt   <= gnt_nxt;
                        ptr   <= (gnt_nxt == 2'd2) ? 2'd0
                                                   : gnt_nxt + 2'd1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    emp     <= sel_empty;
                    lat_cnt <= 2'd0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        tmo_cnt <= 16'd0;
                        state   <= S_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: begin
                    if (ack || tmo_cnt == TMO_LAST)
                        state <= S_IDLE;
                    else
                        tmo_cnt <= tmo_cnt + 16'd1;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            rd_data   <= 32'd0;
            rd_src    <= 2'd0;
            cnt_a     <= 16'd0;
            cnt_b     <= 16'd0;
            cnt_c     <= 16'd0;
            err_empty <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            if (latch) begin
                rd_data <= emp ? EMPTY_WORD : sel_data;
                rd_src  <= gnt;
                if (!emp) begin
                    case (gnt)
                        2'd0:    cnt_a <= cnt_a + 16'd1;
                        2'd1:    cnt_b <= cnt_b + 16'd1;
                        default: cnt_c <= cnt_c + 16'd1;
                    endcase
                end
            end
            if (err_clr)
                err_empty <= 1'b0;
            else if (latch && emp)
                err_empty <= 1'b1;
            if (err_clr)
                err_tmo <= 1'b0;
            else if (tmo_hit)
                err_tmo <= 1'b1;
        end
    end

endmodule
